// File: rtl/gpu_pkg.sv
// gpu_pkg: shared defaults and arbiter state encoding for thread_mem_arbiter.
package gpu_pkg;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after i_ptr.
module rr_arbiter
  import gpu_pkg::*;
#(
  parameter int N = DEF_NUM_THREADS,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_winner,
  output logic         o_any
);
  logic [W-1:0] w_idx;
  always_comb begin
    o_winner = i_ptr;
    o_any = |i_req;
    w_idx = '0;
    // Scan from farthest to nearest so the nearest requester is the last write.
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = W'((int'(i_ptr) + i) % N);
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end
endmodule

// File: rtl/thread_mem_arbiter.sv
// thread_mem_arbiter: round-robin serialiser of per-thread loads/stores into one shared memory.
// Optional ARB_PERF_COUNTERS_EN adds saturating conflict-cycle and grant counters.
module thread_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_THREADS-1:0]            req_valid,
  input  logic [NUM_THREADS-1:0]            req_write,
  input  logic [NUM_THREADS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_THREADS-1:0]            gnt,
  output logic [NUM_THREADS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  input  logic                              host_we,
  input  logic [ADDR_WIDTH-1:0]             host_addr,
  input  logic [DATA_WIDTH-1:0]             host_wdata,
  output logic [DATA_WIDTH-1:0]             host_rdata,
  output logic                              busy
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [15:0]                       perf_conflict_cycles,
  output logic [15:0]                       perf_grants
`endif
);
  localparam int TW = $clog2(NUM_THREADS);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  arb_state_t r_state;
  logic [TW-1:0] r_ptr, r_win, w_win;
  logic w_any, r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [NUM_THREADS-1:0] r_gnt, r_rsp;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  rr_arbiter #(.N(NUM_THREADS), .W(TW)) u_arb (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_winner(w_win),
    .o_any(w_any)
  );
  assign gnt = r_gnt;
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;
  assign host_rdata = r_mem[host_addr];
  assign busy = r_state != ARB_IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_ptr <= '0;
      r_win <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_gnt <= '0;
      r_rsp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_gnt <= '0;
      r_rsp <= '0;
      case (r_state)
        ARB_IDLE: if (w_any) begin
          r_state <= ARB_ACCESS;
          r_win <= w_win;
          r_we <= req_write[w_win];
          r_addr <= req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
          r_wdata <= req_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
          r_gnt <= NUM_THREADS'(1) << w_win;
        end
        ARB_ACCESS: begin
          r_state <= ARB_RESP;
          if (r_we) r_mem[r_addr] <= r_wdata;
          r_rdata <= r_we ? '0 : r_mem[r_addr];
          r_ptr <= (r_win == TW'(NUM_THREADS - 1)) ? '0 : r_win + 1'b1;
          r_rsp <= r_gnt;
        end
        default: begin
          r_state <= ARB_IDLE;
          r_rdata <= '0;
        end
      endcase
      // Last write wins: the host beats a same-address thread store.
      if (host_we) r_mem[host_addr] <= host_wdata;
    end
  end
`ifdef ARB_PERF_COUNTERS_EN
  logic [15:0] r_perf_conf, r_perf_gnt;
  assign perf_conflict_cycles = r_perf_conf;
  assign perf_grants = r_perf_gnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_conf <= '0;
      r_perf_gnt <= '0;
    end else begin
      r_perf_conf <= (|(req_valid & ~r_gnt) && r_perf_conf != 16'hFFFF) ? r_perf_conf + 16'd1 : r_perf_conf;
      r_perf_gnt <= (|r_gnt && r_perf_gnt != 16'hFFFF) ? r_perf_gnt + 16'd1 : r_perf_gnt;
    end
  end
`endif
endmodule

// File: tb/tb_thread_mem_arbiter.sv
// tb_thread_mem_arbiter: directed scenarios checked every cycle against a transaction-level model.
module tb_thread_mem_arbiter;
  logic clk = 0, reset = 0;
  logic [3:0] req_valid = 0, req_write = 0, gnt, rsp_valid;
  logic [19:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [7:0] rsp_rdata, host_wdata = 0, host_rdata;
  logic [4:0] host_addr = 0;
  logic host_we = 0, busy;
`ifdef ARB_PERF_COUNTERS_EN
  logic [15:0] perf_conflict_cycles, perf_grants;
`endif
  int n_tests = 0, n_fail = 0;
  int order[$];
  thread_mem_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .busy(busy)
`ifdef ARB_PERF_COUNTERS_EN
    , .perf_conflict_cycles(perf_conflict_cycles), .perf_grants(perf_grants)
`endif
  );
  always #5 clk = ~clk;
  // Transaction-level model: a request accepted at edge 'acc' is granted after that
  // edge, performs its memory access and responds after acc+1, next accept at acc+3.
  logic [7:0] m_mem [32];
  int cyc, acc, m_ptr, t_win, m_grants;
  logic t_we;
  logic [4:0] t_addr;
  logic [7:0] t_wd, t_rd;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0; acc = -10; m_ptr = 0; t_win = 0; t_we = 0; t_addr = 0; t_wd = 0; t_rd = 0; m_grants = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      cyc++;
      if (cyc == acc + 1) begin
        if (t_we) m_mem[t_addr] = t_wd;
        else t_rd = m_mem[t_addr];
        m_ptr = (t_win + 1) % 4;
      end else if (cyc >= acc + 3 && req_valid != 0) begin
        for (int k = 0; k < 4; k++) begin
          if (req_valid[(m_ptr + k) % 4]) begin
            t_win = (m_ptr + k) % 4;
            break;
          end
        end
        acc = cyc;
        t_we = req_write[t_win];
        t_addr = req_addr[t_win*5 +: 5];
        t_wd = req_wdata[t_win*8 +: 8];
        m_grants++;
      end
      if (host_we) m_mem[host_addr] = host_wdata;
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
    chk("gnt", gnt, (cyc == acc) ? 32'(1 << t_win) : 0);
    chk("rsp_valid", rsp_valid, (cyc == acc + 1) ? 32'(1 << t_win) : 0);
    chk("rsp_rdata", rsp_rdata, (cyc == acc + 1 && !t_we) ? 32'(t_rd) : 0);
    chk("busy", busy, (cyc == acc || cyc == acc + 1) ? 1 : 0);
    chk("host_rdata", host_rdata, m_mem[host_addr]);
    for (int t = 0; t < 4; t++) begin
      if (gnt[t]) begin
        order.push_back(t);
        req_valid[t] = 0;
      end
    end
  endtask
  task automatic post(int t, logic we, logic [4:0] a, logic [7:0] d);
    req_valid[t] = 1;
    req_write[t] = we;
    req_addr[t*5 +: 5] = a;
    req_wdata[t*8 +: 8] = d;
  endtask
  task automatic drain(int max);
    int n = 0;
    while ((req_valid != 0 || busy) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < max, 1);
  endtask
  task automatic do_reset();
    req_valid = 0;
    reset = 0;
    cycle();
    reset = 1;
    cycle();
  endtask
  task automatic host_write(logic [4:0] a, logic [7:0] d);
    host_we = 1; host_addr = a; host_wdata = d;
    cycle();
    host_we = 0;
  endtask
  int ks[4], ka[4], kb[4];
  logic kp[4];
  initial begin
    cycle();
    cycle();
    reset = 1;
    cycle();
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    // single load
    host_write(4, 8'h2A);
    post(2, 0, 4, 0);
    cycle();
    chk("load_gnt", gnt, 4'b0100);
    cycle();
    chk("load_rsp_valid", rsp_valid, 4'b0100);
    chk("load_rsp_rdata", rsp_rdata, 8'h2A);
    cycle();
    // store then host readback
    post(1, 1, 17, 8'h37);
    cycle();
    chk("store_gnt", gnt, 4'b0010);
    cycle();
    chk("store_rsp_valid", rsp_valid, 4'b0010);
    chk("store_rsp_rdata", rsp_rdata, 0);
    host_addr = 17;
    #1;
    chk("store_readback", host_rdata, 8'h37);
    cycle();
    // round-robin from reset
    do_reset();
    order.delete();
    for (int t = 0; t < 4; t++) post(t, 0, 5'(t), 0);
    drain(40);
    post(0, 0, 0, 0);
    drain(10);
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", order[i], i % 4);
    // host/thread collision: store loses to host, load sees pre-write value
    post(0, 1, 16, 8'h11);
    cycle();
    chk("coll_gnt", gnt, 4'b0001);
    host_we = 1; host_addr = 16; host_wdata = 8'hFF;
    cycle();
    host_we = 0;
    #1;
    chk("coll_mem16", host_rdata, 8'hFF);
    cycle();
    post(1, 0, 16, 0);
    cycle();
    host_we = 1; host_wdata = 8'h5A;
    cycle();
    host_we = 0;
    #1;
    chk("coll_load_old", rsp_rdata, 8'hFF);
    chk("coll_host_new", host_rdata, 8'h5A);
    cycle();
    // reset mid-ACCESS drops the transaction
    post(2, 0, 4, 0);
    cycle();
    chk("pre_reset_gnt", gnt, 4'b0100);
    reset = 0;
    req_valid = 0;
    cycle();
    chk("mid_reset_gnt", gnt, 0);
    chk("mid_reset_rsp", rsp_valid, 0);
    chk("mid_reset_busy", busy, 0);
    host_addr = 5;
    #1;
    chk("mid_reset_mem5", host_rdata, 0);
    reset = 1;
    cycle();
    // kernel: each core t computes mem[t]+mem[t+4] into mem[16+t], then reloads it
    do_reset();
    for (int i = 0; i < 8; i++) host_write(5'(i), 8'(i + 1));
    for (int t = 0; t < 4; t++) begin ks[t] = 0; kp[t] = 0; ka[t] = 0; kb[t] = 0; end
    for (int n = 0; n < 400 && (ks[0] + ks[1] + ks[2] + ks[3]) < 16; n++) begin
      for (int t = 0; t < 4; t++) begin
        if (!kp[t] && ks[t] < 4) begin
          kp[t] = 1;
          case (ks[t])
            0: post(t, 0, 5'(t), 0);
            1: post(t, 0, 5'(t + 4), 0);
            2: post(t, 1, 5'(16 + t), 8'(ka[t] + kb[t]));
            default: post(t, 0, 5'(16 + t), 0);
          endcase
        end
      end
      cycle();
      for (int t = 0; t < 4; t++) begin
        if (rsp_valid[t]) begin
          if (ks[t] == 0) ka[t] = rsp_rdata;
          if (ks[t] == 1) kb[t] = rsp_rdata;
          ks[t]++;
          kp[t] = 0;
        end
      end
    end
    chk("kernel_done", ks[0] + ks[1] + ks[2] + ks[3], 16);
    drain(10);
    chk("kernel_model_grants", m_grants, 16);
    for (int i = 0; i < 4; i++) begin
      host_addr = 5'(16 + i);
      #1;
      chk("kernel_result", host_rdata, 6 + 2 * i);
    end
`ifdef ARB_PERF_COUNTERS_EN
    chk("perf_grants", perf_grants, 16);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
